// File: rtl/br_ctrl_pkg.sv
// Shared definitions for the conditional-branch control sequencer:
// state encoding, opcode/ALU encodings, condition codes and strobe decode.
package br_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4
    } state_t;

    localparam logic [4:0] BR_OPCODE = 5'b10010;
    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd3;

    typedef enum logic [1:0] {
        BRZR = 2'd0,
        BRNZ = 2'd1,
        BRPL = 2'd2,
        BRMI = 2'd3
    } cond_t;

    typedef struct packed {
        logic gra;
        logic rout;
        logic conin;
        logic pcout;
        logic yin;
        logic cout;
        logic zin;
        logic zlowout;
        logic pcin;
        logic busy;
        logic done;
    } strobes_t;

    // pcin here means "PC load permitted"; the CON gate is applied at the output.
    function automatic strobes_t decode(input state_t s);
        strobes_t r;
        r         = '0;
        r.busy    = (s != ST_IDLE);
        r.gra     = (s == ST_T3);
        r.rout    = (s == ST_T3);
        r.conin   = (s == ST_T3);
        r.pcout   = (s == ST_T4);
        r.yin     = (s == ST_T4);
        r.cout    = (s == ST_T5);
        r.zin     = (s == ST_T5);
        r.zlowout = (s == ST_T6);
        r.pcin    = (s == ST_T6);
        r.done    = (s == ST_T6);
        return r;
    endfunction

endpackage

// File: rtl/branch_ctrl_seq_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, async active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = cnt_reg;

endmodule

// File: rtl/branch_ctrl_seq.sv
// T3-T6 control-step sequencer for brzr/brnz/brpl/brmi with taken/not-taken
// statistics and detection of start against a non-branch opcode.
module branch_ctrl_seq #(
    parameter logic [4:0] BR_OPCODE = br_ctrl_pkg::BR_OPCODE,
    parameter int         CNT_W     = 16,
    parameter logic [3:0] ALU_ADD   = br_ctrl_pkg::ALU_ADD
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stall,
    input  logic [31:0]      ir,
    input  logic             con,
    output logic             gra,
    output logic             rout,
    output logic             conin,
    output logic             pcout,
    output logic             yin,
    output logic             cout,
    output logic             zin,
    output logic [3:0]       alu_op,
    output logic             zlowout,
    output logic             pcin,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);
    import br_ctrl_pkg::*;

    state_t   state_reg, state_next;
    strobes_t strb_reg, strb_next;
    logic [3:0] alu_reg, alu_next;
    logic       illegal_reg, illegal_next;
    logic       is_branch;
    logic       unused_ir;

    // The condition code is decoded outside this block; only the opcode matters here.
    assign is_branch = (ir[31:27] == BR_OPCODE);
    assign unused_ir = ^ir[26:0];

    always_comb begin
        state_next   = state_reg;
        illegal_next = 1'b0;
        if (!stall) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (is_branch) state_next = ST_T3;
                        else           illegal_next = 1'b1;
                    end
                end
                ST_T3:   state_next = ST_T4;
                ST_T4:   state_next = ST_T5;
                ST_T5:   state_next = ST_T6;
                ST_T6:   state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
        strb_next = decode(state_next);
        alu_next  = (state_next == ST_T5) ? ALU_ADD : ALU_NOP;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= ST_IDLE;
            strb_reg    <= '0;
            alu_reg     <= ALU_NOP;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            strb_reg    <= strb_next;
            alu_reg     <= alu_next;
            illegal_reg <= illegal_next;
        end
    end

    assign gra     = strb_reg.gra;
    assign rout    = strb_reg.rout;
    assign pcout   = strb_reg.pcout;
    assign yin     = strb_reg.yin;
    assign cout    = strb_reg.cout;
    assign zin     = strb_reg.zin;
    assign zlowout = strb_reg.zlowout;
    assign busy    = strb_reg.busy;
    assign alu_op  = alu_reg;
    assign illegal = illegal_reg;

    // Edge-sensitive loads are masked during stall so CON/PC are clocked exactly once.
    assign conin = strb_reg.conin & ~stall;
    assign pcin  = strb_reg.pcin & con & ~stall;
    assign done  = strb_reg.done & ~stall;

    logic             seq_end;
    logic [1:0]       cnt_en;
    logic [CNT_W-1:0] cnt_q [2];

    assign seq_end   = (state_reg == ST_T6) & ~stall;
    assign cnt_en[0] = seq_end & con;
    assign cnt_en[1] = seq_end & ~con;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .clr (clr),
            .en  (cnt_en[gi]),
            .q   (cnt_q[gi])
        );
    end

    assign taken_cnt  = cnt_q[0];
    assign ntaken_cnt = cnt_q[1];

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Self-checking bench for branch_ctrl_seq: directed scenarios followed by random
// branch/illegal/idle traffic, compared cycle by cycle against a behavioural model.
module tb_branch_ctrl_seq;

    logic        clk = 1'b0;
    logic        clr, start, stall, con;
    logic [31:0] ir;

    logic        gra, rout, conin, pcout, yin, cout, zin, zlowout, pcin, busy, done, illegal;
    logic [3:0]  alu_op;
    logic [15:0] taken_cnt, ntaken_cnt;

    logic        b_gra, b_rout, b_conin, b_pcout, b_yin, b_cout, b_zin, b_zlowout, b_pcin;
    logic        b_busy, b_done, b_illegal;
    logic [3:0]  b_alu_op;
    logic [1:0]  b_taken_cnt, b_ntaken_cnt;

    always #5 clk = ~clk;

    branch_ctrl_seq u_dut (
        .clk(clk), .clr(clr), .start(start), .stall(stall), .ir(ir), .con(con),
        .gra(gra), .rout(rout), .conin(conin), .pcout(pcout), .yin(yin),
        .cout(cout), .zin(zin), .alu_op(alu_op), .zlowout(zlowout), .pcin(pcin),
        .busy(busy), .done(done), .illegal(illegal),
        .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
    );

    branch_ctrl_seq #(.CNT_W(2)) u_dut_b (
        .clk(clk), .clr(clr), .start(start), .stall(stall), .ir(ir), .con(con),
        .gra(b_gra), .rout(b_rout), .conin(b_conin), .pcout(b_pcout), .yin(b_yin),
        .cout(b_cout), .zin(b_zin), .alu_op(b_alu_op), .zlowout(b_zlowout), .pcin(b_pcin),
        .busy(b_busy), .done(b_done), .illegal(b_illegal),
        .taken_cnt(b_taken_cnt), .ntaken_cnt(b_ntaken_cnt)
    );

    wire [10:0] obs   = {gra, rout, conin, pcout, yin, cout, zin, zlowout, pcin, busy, done};
    wire [10:0] obs_b = {b_gra, b_rout, b_conin, b_pcout, b_yin, b_cout, b_zin, b_zlowout,
                         b_pcin, b_busy, b_done};

    int          passes = 0;
    int          fails  = 0;
    int          checks = 0;
    int unsigned m_taken  = 0;
    int unsigned m_ntaken = 0;

    // Reference strobe table: ph 0 = idle, 3..6 = control steps T3..T6.
    function automatic logic [10:0] exp_strb(input int ph, input bit stl, input bit cn);
        logic [10:0] e;
        e = {ph == 3, ph == 3, (ph == 3) && !stl, ph == 4, ph == 4, ph == 5, ph == 5,
             ph == 6, (ph == 6) && cn && !stl, ph != 0, (ph == 6) && !stl};
        return e;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_cycle(input string tag, input int ph, input bit stl, input bit cn,
                               input bit ill);
        chk({tag, " strobes"},   {21'd0, obs},   {21'd0, exp_strb(ph, stl, cn)});
        chk({tag, " strobes_b"}, {21'd0, obs_b}, {21'd0, exp_strb(ph, stl, cn)});
        chk({tag, " alu_op"},    {28'd0, alu_op}, (ph == 5) ? 32'd3 : 32'd0);
        chk({tag, " illegal"},   {31'd0, illegal}, {31'd0, ill});
        chk({tag, " taken"},     {16'd0, taken_cnt},  sat(m_taken, 65535));
        chk({tag, " ntaken"},    {16'd0, ntaken_cnt}, sat(m_ntaken, 65535));
        chk({tag, " taken_b"},   {30'd0, b_taken_cnt},  sat(m_taken, 3));
        chk({tag, " ntaken_b"},  {30'd0, b_ntaken_cnt}, sat(m_ntaken, 3));
    endtask

    // One full branch; back-to-back when called consecutively.
    task automatic do_branch(input logic [31:0] irv, input bit cv, input int st_ph,
                             input int st_len, input string tag);
        start = 1'b1; ir = irv; stall = 1'b0; con = 1'($urandom);
        @(negedge clk); check_cycle({tag, " idle"}, 0, 1'b0, con, 1'b0);
        for (int ph = 3; ph <= 6; ph++) begin
            @(posedge clk); #1;
            for (int s = 0; s < ((ph == st_ph) ? st_len : 0); s++) begin
                start = 1'($urandom); stall = 1'b1; con = (ph == 6) ? cv : 1'($urandom);
                @(negedge clk); check_cycle($sformatf("%s T%0d stall%0d", tag, ph, s), ph, 1'b1, con, 1'b0);
                @(posedge clk); #1;
            end
            start = 1'($urandom); stall = 1'b0; con = (ph == 6) ? cv : 1'($urandom);
            @(negedge clk); check_cycle($sformatf("%s T%0d", tag, ph), ph, 1'b0, con, 1'b0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (cv) m_taken++; else m_ntaken++;
        $display("branch %s ir=%08h con=%0d stall_T%0d x%0d taken=%0d ntaken=%0d",
                 tag, irv, cv, st_ph, st_len, m_taken, m_ntaken);
    endtask

    task automatic do_illegal(input logic [31:0] irv, input string tag);
        start = 1'b1; ir = irv; stall = 1'b0;
        @(negedge clk); check_cycle({tag, " req"}, 0, 1'b0, con, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); check_cycle({tag, " pulse"}, 0, 1'b0, con, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); check_cycle({tag, " after"}, 0, 1'b0, con, 1'b0);
        @(posedge clk); #1;
        $display("illegal %s ir=%08h", tag, irv);
    endtask

    task automatic do_idle(input int n, input string tag);
        start = 1'b0; stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            con = 1'($urandom);
            @(negedge clk); check_cycle({tag, " idle"}, 0, 1'b0, con, 1'b0);
            @(posedge clk); #1;
        end
        $display("idle %s cycles=%0d", tag, n);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] rir;
        int          kind;

        clr = 1'b0; start = 1'b0; stall = 1'b0; con = 1'b0; ir = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_cycle("por", 0, 1'b0, con, 1'b0);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        do_idle(2, "post_por");

        do_branch(32'h9000_0000, 1'b1, 0, 0, "brzr_taken");
        do_branch(32'h9000_0000, 1'b0, 0, 0, "brzr_ntaken");
        do_idle(1, "gap");
        do_illegal(32'h1800_0000, "op00011");
        do_branch(32'h9008_0000, 1'b1, 6, 3, "stall_T6");
        do_idle(1, "gap2");

        // Asynchronous reset in the middle of T4.
        start = 1'b1; ir = 32'h9010_0000; con = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check_cycle("pre_reset T4", 4, 1'b0, con, 1'b0);
        #2 clr = 1'b0;
        #1;
        m_taken = 0; m_ntaken = 0;
        check_cycle("reset_midT4", 0, 1'b0, con, 1'b0);
        $display("reset asserted mid-T4");
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        do_idle(3, "post_reset");

        for (int i = 0; i < 5; i++)
            do_branch(32'h9018_0000, 1'b1, 0, 0, $sformatf("b2b%0d", i));
        do_idle(1, "b2b_end");

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 3) begin
                rir = {5'b10010, 27'($urandom)};
                do_branch(rir, 1'($urandom), $urandom_range(3, 6), $urandom_range(0, 3),
                          $sformatf("rnd%0d", i));
            end else if (kind == 4) begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'b10010) op = 5'b00000;
                rir = {op, 27'($urandom)};
                do_illegal(rir, $sformatf("rnd%0d", i));
            end else begin
                do_idle($urandom_range(1, 3), $sformatf("rnd%0d", i));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
